serial_operand_shifter: RTL and testbench



---
 rtl/serial_operand_shifter_pkg.sv | 13 +
 rtl/serial_operand_shifter_piso_lane.sv | 23 ++
 rtl/serial_operand_shifter.sv | 94 +++++++++
 tb/tb_serial_operand_shifter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_operand_shifter_pkg.sv
// Shared types and sizing helpers for the serial operand shifter.
package serial_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Counter must reach WIDTH+PAD once the final bit is consumed.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned pad);
    return $clog2(width + pad + 1);
  endfunction

endpackage

// File: rtl/serial_operand_shifter_piso_lane.sv
// Parallel-load, right-shift register with zero fill; q is the current LSB.
module piso_lane #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r <= '0;
    else if (ld) r <= d;
    else if (sh) r <= {1'b0, r[WIDTH-1:1]};
  end

  assign q = r[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// Two-lane LSB-first serializer with PAD trailing zero bits, stall input and done pulse.
module serial_operand_shifter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned PAD   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hold,
  output logic             ready,
  output logic             a_ser,
  output logic             b_ser,
  output logic             en,
  output logic             done
);

  localparam int unsigned CW   = cnt_width(WIDTH, PAD);
  localparam int unsigned LAST = WIDTH + PAD - 1;

  ser_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          en_nxt, done_nxt, ready_nxt;
  logic          ld, sh, last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (en && (cnt == CW'(LAST))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A bit is consumed on any SHIFT edge where it was presented with en=1;
  // hold sampled at that edge decides whether the next bit is qualified.
  always_comb begin
    ld        = (state == IDLE) && load;
    sh        = (state == SHIFT) && en;
    last      = sh && (cnt == CW'(LAST));
    cnt_nxt   = cnt;
    en_nxt    = 1'b0;
    done_nxt  = last;
    ready_nxt = (state_nxt == IDLE);
    if (ld) begin
      cnt_nxt = '0;
      en_nxt  = !hold;
    end else if (state == SHIFT) begin
      if (sh) cnt_nxt = cnt + CW'(1);
      en_nxt = !hold && !last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      en    <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      en    <= en_nxt;
      done  <= done_nxt;
      ready <= ready_nxt;
    end
  end

  piso_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .sh  (sh),
    .d   (a_in),
    .q   (a_ser)
  );

  piso_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .sh  (sh),
    .d   (b_in),
    .q   (b_ser)
  );

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Self-checking bench: queue-based bit-stream reference model plus directed and random stimulus.
module tb_serial_operand_shifter;

  localparam int unsigned W = 8;
  localparam int unsigned P = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] a_in, b_in;
  logic         hold;
  logic         ready, a_ser, b_ser, en, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: pending bit pairs of the word in flight
  bit   qa[$];
  bit   qb[$];
  logic m_busy, m_en, m_done, m_ready, m_a, m_b;

  // observation logs
  bit   obs_a[$];
  bit   obs_b[$];
  int   firsts[$];
  int   done_cyc;
  logic prev_en;

  serial_operand_shifter #(.WIDTH(W), .PAD(P)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .a_in  (a_in),
    .b_in  (b_in),
    .hold  (hold),
    .ready (ready),
    .a_ser (a_ser),
    .b_ser (b_ser),
    .en    (en),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_busy = 1'b0; m_en = 1'b0; m_done = 1'b0; m_ready = 1'b1; m_a = 1'b0; m_b = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic [W-1:0] a, input logic [W-1:0] b, input logic h);
    m_done = 1'b0;
    if (m_busy) begin
      if (m_en) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (qa.size() == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_en = 1'b0;
      end else begin
        m_en = !h;
      end
    end else if (l) begin
      for (int i = 0; i < int'(W + P); i++) begin
        qa.push_back((i < int'(W)) ? a[i] : 1'b0);
        qb.push_back((i < int'(W)) ? b[i] : 1'b0);
      end
      m_busy = 1'b1;
      m_en   = !h;
    end else begin
      m_en = 1'b0;
    end
    m_ready = !m_busy;
    m_a     = m_busy ? qa[0] : 1'b0;
    m_b     = m_busy ? qb[0] : 1'b0;
  endtask

  task automatic clear_logs();
    obs_a.delete();
    obs_b.delete();
    firsts.delete();
    done_cyc = -1;
    prev_en  = 1'b0;
  endtask

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] r = '0;
    for (int i = 0; i < q.size() && i < 32; i++) r[i] = q[i];
    return r;
  endfunction

  // One clock: drive at the falling edge, advance the model, observe at the next falling edge.
  task automatic step(input logic l, input logic [W-1:0] a, input logic [W-1:0] b, input logic h);
    load = l; a_in = a; b_in = b; hold = h;
    model_edge(l, a, b, h);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("ready", 32'(ready), 32'(m_ready));
    check("en",    32'(en),    32'(m_en));
    check("a_ser", 32'(a_ser), 32'(m_a));
    check("b_ser", 32'(b_ser), 32'(m_b));
    check("done",  32'(done),  32'(m_done));
    if (en) begin
      obs_a.push_back(a_ser);
      obs_b.push_back(b_ser);
      if (!prev_en) firsts.push_back(cyc);
    end
    if (done) done_cyc = cyc;
    prev_en = en;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_en"},    32'(en),    32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_a"},     32'(a_ser), 32'd0);
    check({tag, "_b"},     32'(b_ser), 32'd0);
  endtask

  int t0;

  initial begin
    rst = 1'b0; load = 1'b0; a_in = '0; b_in = '0; hold = 1'b0;
    model_reset();
    clear_logs();

    // reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("rst");
    end
    rst = 1'b1;
    repeat (2) step(1'b0, '0, '0, 1'b0);

    // single word
    clear_logs(); t0 = cyc;
    step(1'b1, 8'hB5, 8'h3C, 1'b0);
    repeat (11) step(1'b0, '0, '0, 1'b0);
    check("single_a",    pack(obs_a), 32'h0B5);
    check("single_b",    pack(obs_b), 32'h03C);
    check("single_len",  32'(obs_a.size()), 32'd9);
    check("single_done", 32'(done_cyc - t0), 32'd10);

    // back-to-back with load held high
    clear_logs();
    step(1'b1, 8'hFF, 8'h01, 1'b0);
    repeat (10) step(1'b1, 8'h00, 8'hAA, 1'b0);
    repeat (12) step(1'b0, '0, '0, 1'b0);
    check("b2b_words", 32'(firsts.size()), 32'd2);
    if (firsts.size() == 2) check("b2b_spacing", 32'(firsts[1] - firsts[0]), 32'd10);
    check("b2b_len", 32'(obs_a.size()), 32'd18);
    check("b2b_a",   pack(obs_a), 32'h000FF);
    check("b2b_b",   pack(obs_b), 32'h15401);

    // hold for three cycles after bit 3
    clear_logs(); t0 = cyc;
    step(1'b1, 8'hB5, 8'h3C, 1'b0);
    repeat (3)  step(1'b0, '0, '0, 1'b0);
    repeat (3)  step(1'b0, '0, '0, 1'b1);
    repeat (10) step(1'b0, '0, '0, 1'b0);
    check("hold_a",    pack(obs_a), 32'h0B5);
    check("hold_b",    pack(obs_b), 32'h03C);
    check("hold_len",  32'(obs_a.size()), 32'd9);
    check("hold_done", 32'(done_cyc - t0), 32'd13);

    // load while busy is ignored
    clear_logs();
    step(1'b1, 8'hB5, 8'h3C, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b0);
    step(1'b1, 8'h12, 8'h34, 1'b0);
    repeat (12) step(1'b0, '0, '0, 1'b0);
    check("ign_a",     pack(obs_a), 32'h0B5);
    check("ign_b",     pack(obs_b), 32'h03C);
    check("ign_words", 32'(firsts.size()), 32'd1);

    // asynchronous reset mid-word
    step(1'b1, 8'hB5, 8'h3C, 1'b0);
    repeat (5) step(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    model_reset();
    @(posedge clk); #1;
    check_idle_outputs("abort_hold");
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    step(1'b1, 8'h0F, 8'hF0, 1'b0);
    repeat (11) step(1'b0, '0, '0, 1'b0);
    check("abort_a",   pack(obs_a), 32'h00F);
    check("abort_b",   pack(obs_b), 32'h0F0);
    check("abort_len", 32'(obs_a.size()), 32'd9);

    // random load/hold/data traffic
    repeat (600) begin
      step(1'($urandom_range(0, 3) == 0), W'($urandom), W'($urandom),
           1'($urandom_range(0, 3) == 0));
    end
    repeat (20) step(1'b0, '0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
